bit_16_reg: RTL and testbench
=============================

BIT_16_REG -- requirements
Module: bit_16_reg

Interface
REQ-001 Parameter RESET_VAL, default 16'h0000, value loaded into Q on reset.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  load enable; high loads D on the next rising clk edge.
REQ-005 D  input  16  data to be loaded.
REQ-006 Q  output  16  registered value, driven directly from the storage flops.
REQ-007 Q_par  output  1  even parity of Q; present only when BIT_16_REG_PARITY_EN is defined.

Function
REQ-008 All state changes SHALL occur only on the rising edge of clk; no combinational path from D, en or reset to Q.
REQ-009 At a rising edge with reset=1, Q SHALL become RESET_VAL regardless of en and D.
REQ-010 At a rising edge with reset=0 and en=1, Q SHALL become D as sampled at that edge; latency is one cycle.
REQ-011 At a rising edge with reset=0 and en=0, Q SHALL hold its previous value.
REQ-012 Priority SHALL be reset > en > hold.
REQ-013 All 16 bits SHALL load and reset together; no partial or byte-wise writes.
REQ-014 D changing while en=0 SHALL have no effect on Q.
REQ-015 Q SHALL be usable as a feedback source, e.g. D = Q+1; the new value appears one cycle after the edge that samples it.
REQ-016 Before the first reset edge, Q SHALL be undefined; users must apply reset for at least one clk edge.

Reset
REQ-017 Reset SHALL be synchronous and active-high; asserting reset between edges SHALL not change Q until the next rising edge.
REQ-018 Reset asserted in the same cycle as en=1 SHALL yield RESET_VAL, and D SHALL be discarded.
REQ-019 After reset deasserts, the first edge with en=1 SHALL load D normally.

Configuration
REQ-020 Macro BIT_16_REG_PARITY_EN:
- Defined: Q_par exists and equals the XOR of all Q bits, registered alongside Q.
- Q_par follows Q's reset, load and hold behaviour.
- Q_par resets to the parity of RESET_VAL.
REQ-021 Without BIT_16_REG_PARITY_EN, Q_par and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-022 Shared package bit_16_reg_pkg SHALL hold the constant WORD_W = 16, a word typedef of WORD_W bits, and the default reset constant 16'h0000.
REQ-023 The parity function SHALL be a sub-module, bit_16_reg_par, instantiated only under BIT_16_REG_PARITY_EN; the storage SHALL be a single always block in the top module.

Verification
REQ-024 Reset=1, en=0, D=16'hFFFF for one edge -> Q=16'h0000 (Q_par=0 if enabled).
REQ-025 Reset=0, en=1, D=16'hA5C3 -> Q=16'hA5C3 after exactly one edge; Q unchanged before that edge.
REQ-026 en=0, D toggled 16'h1234 -> 16'hFFFF over 3 edges -> Q holds 16'hA5C3 throughout.
REQ-027 Reset=1 and en=1 with D=16'h7777 at the same edge -> Q=16'h0000.
REQ-028 Feedback count: D=Q+1, en=1, starting at 16'hFFFE -> Q goes 16'hFFFF, then 16'h0000 (wrap-around).
REQ-029 With BIT_16_REG_PARITY_EN defined, load 16'h0001 -> Q_par=1; load 16'h0003 -> Q_par=0.

Source files
------------

// File: rtl/bit_16_reg_pkg.sv
// Shared constants and word type for the 16-bit load-enable register.
package bit_16_reg_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_VAL_DEFAULT = 16'h0000;

endpackage

// File: rtl/bit_16_reg_par.sv
// Even-parity generator for one register word; used only when BIT_16_REG_PARITY_EN is defined.
module bit_16_reg_par
    import bit_16_reg_pkg::*;
(
    input  word_t data_i,
    output logic  par_o
);

    assign par_o = ^data_i;

endmodule

// File: rtl/bit_16_reg.sv
// 16-bit register with load enable and synchronous active-high reset.
// Define BIT_16_REG_PARITY_EN to add a registered even-parity output Q_par.
module bit_16_reg
    import bit_16_reg_pkg::*;
#(
    parameter word_t RESET_VAL = RESET_VAL_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  word_t D,
    output word_t Q
`ifdef BIT_16_REG_PARITY_EN
    ,
    output logic  Q_par
`endif
);

    word_t q_q;
    word_t q_d;

`ifdef BIT_16_REG_PARITY_EN
    localparam logic RESET_PAR = ^RESET_VAL;

    logic d_par;
    logic par_q;
    logic par_d;

    // Parity is taken from D so it lands in the same edge as the word it describes.
    bit_16_reg_par u_par (
        .data_i (D),
        .par_o  (d_par)
    );

    always_comb begin
        par_d = par_q;
        if (en) begin
            par_d = d_par;
        end
    end

    assign Q_par = par_q;
`endif

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VAL;
`ifdef BIT_16_REG_PARITY_EN
            par_q <= RESET_PAR;
`endif
        end else begin
            q_q <= q_d;
`ifdef BIT_16_REG_PARITY_EN
            par_q <= par_d;
`endif
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_bit_16_reg.sv
// Directed self-checking bench for bit_16_reg; parity checks compile in with BIT_16_REG_PARITY_EN.
module tb_bit_16_reg;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] D;
    logic [15:0] Q;
`ifdef BIT_16_REG_PARITY_EN
    logic        Q_par;
`endif

    int pass_cnt;
    int total_cnt;

    bit_16_reg dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .D     (D),
        .Q     (Q)
`ifdef BIT_16_REG_PARITY_EN
        ,
        .Q_par (Q_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        D     = 16'hFFFF;
        tick();
        total_cnt++;
        if (Q !== 16'h0000) $display("FAIL reset_q: got %h expected %h", Q, 16'h0000);
        else pass_cnt++;
`ifdef BIT_16_REG_PARITY_EN
        total_cnt++;
        if (Q_par !== 1'b0) $display("FAIL reset_par: got %b expected %b", Q_par, 1'b0);
        else pass_cnt++;
`endif
    endtask

    task automatic test_load();
        reset = 1'b0;
        en    = 1'b1;
        D     = 16'hA5C3;
        #2;
        total_cnt++;
        if (Q !== 16'h0000) $display("FAIL load_before_edge: got %h expected %h", Q, 16'h0000);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (Q !== 16'hA5C3) $display("FAIL load_after_edge: got %h expected %h", Q, 16'hA5C3);
        else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_hold();
        logic [15:0] vals [3];
        vals[0] = 16'h1234;
        vals[1] = 16'hFFFF;
        vals[2] = 16'h0F0F;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            D = vals[i];
            tick();
            total_cnt++;
            if (Q !== 16'hA5C3) $display("FAIL hold_%0d: got %h expected %h", i, Q, 16'hA5C3);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        en    = 1'b1;
        D     = 16'h7777;
        tick();
        total_cnt++;
        if (Q !== 16'h0000) $display("FAIL reset_over_en: got %h expected %h", Q, 16'h0000);
        else pass_cnt++;
    endtask

    task automatic test_release();
        reset = 1'b0;
        en    = 1'b1;
        D     = 16'hBEEF;
        tick();
        total_cnt++;
        if (Q !== 16'hBEEF) $display("FAIL first_load_after_reset: got %h expected %h", Q, 16'hBEEF);
        else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_sync_reset();
        reset = 1'b1;
        en    = 1'b0;
        #2;
        total_cnt++;
        if (Q !== 16'hBEEF) $display("FAIL reset_mid_cycle: got %h expected %h", Q, 16'hBEEF);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (Q !== 16'h0000) $display("FAIL reset_at_edge: got %h expected %h", Q, 16'h0000);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_feedback();
        logic [15:0] exp_vals [3];
        exp_vals[0] = 16'hFFFF;
        exp_vals[1] = 16'h0000;
        exp_vals[2] = 16'h0001;
        en = 1'b1;
        D  = 16'hFFFE;
        tick();
        total_cnt++;
        if (Q !== 16'hFFFE) $display("FAIL feedback_seed: got %h expected %h", Q, 16'hFFFE);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            D = Q + 16'd1;
            tick();
            total_cnt++;
            if (Q !== exp_vals[i]) $display("FAIL feedback_%0d: got %h expected %h", i, Q, exp_vals[i]);
            else pass_cnt++;
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'h8000;
        vals[1] = 16'h5555;
        vals[2] = 16'hAAAA;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D = vals[i];
            tick();
            total_cnt++;
            if (Q !== vals[i]) $display("FAIL back_to_back_%0d: got %h expected %h", i, Q, vals[i]);
            else pass_cnt++;
        end
        en = 1'b0;
    endtask

`ifdef BIT_16_REG_PARITY_EN
    task automatic test_parity();
        logic [15:0] vals [4];
        logic        pars [4];
        vals[0] = 16'h0001; pars[0] = 1'b1;
        vals[1] = 16'h0003; pars[1] = 1'b0;
        vals[2] = 16'h8001; pars[2] = 1'b0;
        vals[3] = 16'h7FFF; pars[3] = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            D = vals[i];
            tick();
            total_cnt++;
            if (Q_par !== pars[i]) $display("FAIL parity_%0d: got %b expected %b", i, Q_par, pars[i]);
            else pass_cnt++;
        end
        en = 1'b0;
        D  = 16'h0001;
        tick();
        total_cnt++;
        if (Q_par !== 1'b1) $display("FAIL parity_hold: got %b expected %b", Q_par, 1'b1);
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b0;
        en    = 1'b0;
        D     = 16'h0000;
        #2;
        test_reset();
        test_load();
        test_hold();
        test_reset_priority();
        test_release();
        test_sync_reset();
        test_feedback();
        test_back_to_back();
`ifdef BIT_16_REG_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
